// File: rtl/wb_stage_param.sv
// -----------------------------------------------------------------------------
// wb_stage_param -- write-back stage with a two-entry FIFO-ordered buffer.
//
// Each accepted entry captures {we, rd, data}. The data is selected from one of
// four candidate results by in_src_sel. The oldest entry (the head) drives the
// register-file write port. The head retires when the write port is free, or
// at once when the entry does not write. retire_cnt counts retired entries and
// wraps at its width.
//
// Optional feature: define WB_FWD_EN to enable the bypass outputs fwd_*. These
// show the youngest buffered entry with we=1. Without the macro, fwd_* are
// tied to zero.
//
// Parameters:
//   DATA_W   register data width
//   ADDR_W   destination register address width
//   RET_W    retire counter width
// Ports:
//   clk                          clock, rising edge
//   reset                        synchronous, active-high reset
//   flush                        discard all buffered entries
//   in_valid / in_ready          upstream handshake
//   in_src_sel                   0 alu, 1 mem, 2 imm, 3 pc
//   in_alu/in_mem/in_imm/in_pc   candidate results
//   in_rd, in_we                 destination register and write enable
//   rf_ready                     register-file write port free this cycle
//   rf_we/rf_waddr/rf_wdata      register-file write
//   retire_cnt                   count of retired entries
//   fwd_valid/fwd_addr/fwd_data  bypass of youngest writing entry
// -----------------------------------------------------------------------------
module wb_stage_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int RET_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_src_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [RET_W-1:0]  retire_cnt,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    // Slot 0 is always the head. Slot 1 holds the younger entry when count==2.
    // Vacated slots are cleared to zero.
    logic [1:0]             r_count;
    logic [1:0]             r_we;
    logic [1:0][ADDR_W-1:0] r_rd;
    logic [1:0][DATA_W-1:0] r_data;
    logic [RET_W-1:0]       r_retire_cnt;

    logic                   w_head_valid;
    logic                   w_retire;
    logic                   w_accept;
    logic                   w_wr_idx;
    logic [DATA_W-1:0]      w_sel_data;
    logic [1:0]             w_count_nx;
    logic [1:0]             w_we_nx;
    logic [1:0][ADDR_W-1:0] w_rd_nx;
    logic [1:0][DATA_W-1:0] w_data_nx;
    logic [RET_W-1:0]       w_retire_cnt_nx;

    function automatic logic [DATA_W-1:0] f_src_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] pc
    );
        logic [DATA_W-1:0] res;
        case (sel)
            2'd0:    res = alu;
            2'd1:    res = mem;
            2'd2:    res = imm;
            2'd3:    res = pc;
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    assign in_ready     = (r_count < 2'd2);
    assign w_head_valid = (r_count != 2'd0);
    // A non-writing head does not need the write port, so it retires at once.
    assign w_retire     = w_head_valid && (rf_ready || !r_we[0]);
    assign w_accept     = in_valid && in_ready && !flush;
    assign w_sel_data   = f_src_mux(in_src_sel, in_alu, in_mem, in_imm, in_pc);
    // A new entry lands behind whatever survives this edge. If a retire
    // happens together with an accept, count was 1, so the new entry becomes
    // the head.
    assign w_wr_idx     = w_retire ? 1'b0 : r_count[0];

    // Next-state computation for the buffer and the retire counter.
    always_comb begin
        w_count_nx      = r_count;
        w_we_nx         = r_we;
        w_rd_nx         = r_rd;
        w_data_nx       = r_data;
        w_retire_cnt_nx = r_retire_cnt;
        if (flush) begin
            w_count_nx = 2'd0;
            w_we_nx    = 2'b00;
            w_rd_nx    = '0;
            w_data_nx  = '0;
        end else begin
            if (w_retire) begin
                w_we_nx[0]      = r_we[1];
                w_rd_nx[0]      = r_rd[1];
                w_data_nx[0]    = r_data[1];
                w_we_nx[1]      = 1'b0;
                w_rd_nx[1]      = {ADDR_W{1'b0}};
                w_data_nx[1]    = {DATA_W{1'b0}};
                w_retire_cnt_nx = r_retire_cnt + {{(RET_W-1){1'b0}}, 1'b1};
            end else begin
                w_retire_cnt_nx = r_retire_cnt;
            end
            if (w_accept) begin
                w_we_nx[w_wr_idx]   = in_we;
                w_rd_nx[w_wr_idx]   = in_rd;
                w_data_nx[w_wr_idx] = w_sel_data;
            end else begin
                w_count_nx = r_count;
            end
            w_count_nx = r_count + {1'b0, w_accept} - {1'b0, w_retire};
        end
    end

    // State registers with synchronous reset that overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= 2'd0;
            r_we         <= 2'b00;
            r_rd         <= '0;
            r_data       <= '0;
            r_retire_cnt <= {RET_W{1'b0}};
        end else begin
            r_count      <= w_count_nx;
            r_we         <= w_we_nx;
            r_rd         <= w_rd_nx;
            r_data       <= w_data_nx;
            r_retire_cnt <= w_retire_cnt_nx;
        end
    end

    assign rf_we      = w_head_valid && r_we[0];
    assign rf_waddr   = w_head_valid ? r_rd[0]   : {ADDR_W{1'b0}};
    assign rf_wdata   = w_head_valid ? r_data[0] : {DATA_W{1'b0}};
    assign retire_cnt = r_retire_cnt;

`ifdef WB_FWD_EN
    // Bypass selection: the youngest buffered entry that writes wins.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = {ADDR_W{1'b0}};
        fwd_data  = {DATA_W{1'b0}};
        if ((r_count == 2'd2) && r_we[1]) begin
            fwd_valid = 1'b1;
            fwd_addr  = r_rd[1];
            fwd_data  = r_data[1];
        end else if ((r_count != 2'd0) && r_we[0]) begin
            fwd_valid = 1'b1;
            fwd_addr  = r_rd[0];
            fwd_data  = r_data[0];
        end else begin
            fwd_valid = 1'b0;
            fwd_addr  = {ADDR_W{1'b0}};
            fwd_data  = {DATA_W{1'b0}};
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = {ADDR_W{1'b0}};
    assign fwd_data  = {DATA_W{1'b0}};
`endif

endmodule

// File: doc/wb_stage_param.md
WB_STAGE_PARAM -- requirements
Module: wb_stage_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width.
REQ-002 SHALL have parameter ADDR_W, default 3, destination register address width.
REQ-003 SHALL have parameter RET_W, default 16, retire counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all buffered entries.
REQ-007 SHALL have port in_valid  input  1  upstream entry valid.
REQ-008 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-009 SHALL have port in_src_sel  input  2  result source: 0 alu, 1 mem, 2 imm, 3 pc.
REQ-010 SHALL have ports in_alu, in_mem, in_imm, in_pc  input  DATA_W each  candidate results.
REQ-011 SHALL have port in_rd  input  ADDR_W  destination register.
REQ-012 SHALL have port in_we  input  1  entry writes the register file.
REQ-013 SHALL have port rf_ready  input  1  register file write port free this cycle.
REQ-014 SHALL have ports rf_we  output  1, rf_waddr  output  ADDR_W, rf_wdata  output  DATA_W  register file write.
REQ-015 SHALL have port retire_cnt  output  RET_W  count of retired entries.
REQ-016 SHALL have ports fwd_valid  output  1, fwd_addr  output  ADDR_W, fwd_data  output  DATA_W  bypass.

Function
REQ-017 SHALL hold up to 2 entries {we, rd, data} in a FIFO-ordered buffer; count in 0..2.
REQ-018 SHALL drive in_ready = (count < 2), combinational from registered count only.
REQ-019 SHALL accept an entry on a rising edge with in_valid && in_ready && !flush, storing data = mux(in_src_sel) captured that cycle.
REQ-020 SHALL drive rf_we = head_valid && head_we; rf_waddr/rf_wdata = head rd/data, zero when buffer empty.
REQ-021 SHALL retire the head when head_valid && (rf_ready || !head_we); an entry with we=0 retires in one cycle regardless of rf_ready.
REQ-022 SHALL have latency 1: an entry accepted at edge N appears on rf_* in cycle N+1 when buffer was empty; no same-cycle pass-through.
REQ-023 SHALL support simultaneous accept and retire in one edge with count unchanged.
REQ-024 SHALL, when count==2, deassert in_ready; an offered entry is neither accepted nor lost (upstream holds).
REQ-025 SHALL hold head stable while rf_we && !rf_ready (stall).
REQ-026 SHALL, on flush, set count to 0 at that edge; flush has priority over accept and retire; no retire counted that edge.
REQ-027 SHALL increment retire_cnt by 1 per retired entry, wrapping from 2^RET_W-1 to 0; flush does not clear it.

Reset
REQ-028 SHALL, on reset at a rising edge, set count=0, retire_cnt=0, all buffer fields 0; reset overrides flush, accept and retire.
REQ-029 SHALL therefore present in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, fwd_addr=0, fwd_data=0 after reset.

Configuration
REQ-030 SHALL implement forwarding only when macro WB_FWD_EN is defined: fwd_* reflects the youngest buffered entry with we=1 (fwd_valid=1), else fwd_valid=0 and fwd_addr/fwd_data=0.
REQ-031 SHALL, without WB_FWD_EN, tie fwd_valid, fwd_addr, fwd_data to 0 and instantiate no forwarding logic.

Verification
REQ-032 SHALL test latency: reset, in_valid=1 sel=1 in_mem=8'hA5 rd=3 we=1, rf_ready=1 -> next cycle rf_we=1 waddr=3 wdata=A5, retire_cnt=1 after that edge.
REQ-033 SHALL test backpressure: rf_ready=0, push 3 entries (alu 8'h11, 8'h22, 8'h33) -> in_ready=0 after 2 accepts; release rf_ready -> writes 11 then 22 then 33 in order.
REQ-034 SHALL test we=0: push imm=8'h7F we=0 with rf_ready=0 -> rf_we stays 0, entry retires next cycle, retire_cnt increments.
REQ-035 SHALL test flush: 2 entries buffered, flush=1 with in_valid=1 -> count=0, offered entry dropped, retire_cnt unchanged, rf_we=0 next cycle.
REQ-036 SHALL test wrap and forwarding: RET_W=4, retire 17 entries -> retire_cnt=1; with WB_FWD_EN, buffered entries rd=2 (8'h10) then rd=5 (8'h20) stalled -> fwd_addr=5 fwd_data=8'h20.
